// File: rtl/clock_pkg.sv
// Shared constants for the clock display path.
//   - Active-low common-anode segment patterns, bit order {dp,g,f,e,d,c,b,a}
//   - Digit index constants, left (hours tens) to right (seconds units)
//   - Decimal-point mask and a digit-enable helper
// No ports; imported by bcd_to_seg7 and clock_display_scan.
package clock_pkg;

  localparam int NUM_DIGITS = 6;

  typedef logic [3:0] bcd_t;
  typedef logic [2:0] digit_idx_t;

  // Segment patterns, active-low, dp off (bit7 = 1).
  localparam logic [7:0] SEG_0    = 8'hC0;
  localparam logic [7:0] SEG_1    = 8'hF9;
  localparam logic [7:0] SEG_2    = 8'hA4;
  localparam logic [7:0] SEG_3    = 8'hB0;
  localparam logic [7:0] SEG_4    = 8'h99;
  localparam logic [7:0] SEG_5    = 8'h92;
  localparam logic [7:0] SEG_6    = 8'h82;
  localparam logic [7:0] SEG_7    = 8'hF8;
  localparam logic [7:0] SEG_8    = 8'h80;
  localparam logic [7:0] SEG_9    = 8'h90;
  localparam logic [7:0] SEG_DASH = 8'hBF;
  localparam logic [7:0] SEG_OFF  = 8'hFF;

  // Digit positions on the display.
  localparam digit_idx_t DIGIT_HH = 3'd0;
  localparam digit_idx_t DIGIT_HL = 3'd1;
  localparam digit_idx_t DIGIT_MH = 3'd2;
  localparam digit_idx_t DIGIT_ML = 3'd3;
  localparam digit_idx_t DIGIT_SH = 3'd4;
  localparam digit_idx_t DIGIT_SL = 3'd5;

  // AND-ing with this lights the decimal point (active-low bit7).
  localparam logic [7:0] DP_MASK = 8'h7F;

  // Active-low one-cold digit enable for a given scan position.
  function automatic logic [NUM_DIGITS-1:0] dig_enable(input digit_idx_t idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder for a common-anode display.
// Ports:
//   bcd  in  4  BCD digit; values above 9 decode to a dash
//   seg  out 7  segments {g,f,e,d,c,b,a}, active-low
module bcd_to_seg7
  import clock_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH[6:0];
    case (bcd)
      4'd0: seg = SEG_0[6:0];
      4'd1: seg = SEG_1[6:0];
      4'd2: seg = SEG_2[6:0];
      4'd3: seg = SEG_3[6:0];
      4'd4: seg = SEG_4[6:0];
      4'd5: seg = SEG_5[6:0];
      4'd6: seg = SEG_6[6:0];
      4'd7: seg = SEG_7[6:0];
      4'd8: seg = SEG_8[6:0];
      4'd9: seg = SEG_9[6:0];
      default: seg = SEG_DASH[6:0];
    endcase
  end

endmodule

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed common-anode display driver for the main_clock time bus,
// shown as HH.MM.SS. The six BCD digits and isFull are captured once per scan
// frame (on the edge that wraps from the last digit back to the first), so a
// frame never mixes digits from two different times.
//
// Optional feature macro: DISP_FULL_BLINK_EN
//   Defined     - while the captured isFull is 1, the display blinks: BLINK_FRAMES
//                 frames visible, BLINK_FRAMES frames dark, repeating. DIG keeps
//                 scanning while dark. Each new isFull assertion starts visible.
//   Not defined - isFull is ignored and SEG is never forced dark.
//
// Parameters:
//   SCAN_DIV      clock cycles each digit stays lit (>= 2)
//   BLINK_FRAMES  frames per blink half-period (blink build only)
// Ports:
//   CLK     in   1  system clock
//   RST     in   1  asynchronous reset, active-low
//   Hh,Hl   in   4  hour tens/units, BCD
//   Mh,Ml   in   4  minute tens/units, BCD
//   Sh,Sl   in   4  second tens/units, BCD
//   isFull  in   1  on-the-hour level
//   SEG     out  8  segments {dp,g,f,e,d,c,b,a}, active-low
//   DIG     out  6  digit enables, active-low; bit0 = Hh ... bit5 = Sl
module clock_display_scan
  import clock_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 83
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] Hh,
  input  logic [3:0] Hl,
  input  logic [3:0] Mh,
  input  logic [3:0] Ml,
  input  logic [3:0] Sh,
  input  logic [3:0] Sl,
  input  logic       isFull,
  output logic [7:0] SEG,
  output logic [5:0] DIG
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0]  prescaler;
  digit_idx_t     idx;
  logic           tc;
  logic           wrap;
  bcd_t           snap [NUM_DIGITS];
  bcd_t           cur_bcd;
  logic [6:0]     cur_seg7;
  logic           blank;
  logic [7:0]     seg_next;
  logic [7:0]     seg_q;
  logic [5:0]     dig_q;

  assign tc   = (prescaler == PW'(SCAN_DIV - 1));
  assign wrap = tc && (idx == DIGIT_SL);

  // Prescaler and scan index.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prescaler <= '0;
      idx       <= DIGIT_HH;
    end else if (tc) begin
      prescaler <= '0;
      idx       <= (idx == DIGIT_SL) ? DIGIT_HH : idx + 3'd1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Digit snapshot, taken only on the frame wrap so a frame never tears.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NUM_DIGITS; i++) snap[i] <= '0;
    end else if (wrap) begin
      snap[DIGIT_HH] <= Hh;
      snap[DIGIT_HL] <= Hl;
      snap[DIGIT_MH] <= Mh;
      snap[DIGIT_ML] <= Ml;
      snap[DIGIT_SH] <= Sh;
      snap[DIGIT_SL] <= Sl;
    end
  end

`ifdef DISP_FULL_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic          snap_full;
  logic [FW-1:0] frame_cnt;
  logic          blank_q;

  // Blink phase advances only at frame wraps. A frame that still had
  // isFull=1 captured and is followed by another isFull=1 frame counts
  // toward the half-period; anything else restarts in the visible phase,
  // so the first frame of a new assertion is always visible.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      snap_full <= 1'b0;
      frame_cnt <= '0;
      blank_q   <= 1'b0;
    end else if (wrap) begin
      snap_full <= isFull;
      if (isFull && snap_full) begin
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          blank_q   <= ~blank_q;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end else begin
        frame_cnt <= '0;
        blank_q   <= 1'b0;
      end
    end
  end

  assign blank = blank_q;
`else
  logic unused_full;
  int   unused_blink_frames;

  assign unused_full         = isFull;
  assign unused_blink_frames = BLINK_FRAMES;
  assign blank               = 1'b0;
`endif

  // Snapshot mux feeding the single decoder.
  always_comb begin
    cur_bcd = snap[DIGIT_HH];
    case (idx)
      DIGIT_HH: cur_bcd = snap[DIGIT_HH];
      DIGIT_HL: cur_bcd = snap[DIGIT_HL];
      DIGIT_MH: cur_bcd = snap[DIGIT_MH];
      DIGIT_ML: cur_bcd = snap[DIGIT_ML];
      DIGIT_SH: cur_bcd = snap[DIGIT_SH];
      DIGIT_SL: cur_bcd = snap[DIGIT_SL];
      default:  cur_bcd = snap[DIGIT_HH];
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd (cur_bcd),
    .seg (cur_seg7)
  );

  // Decimal point after hours units and minutes units gives HH.MM.SS.
  always_comb begin
    seg_next = {1'b1, cur_seg7};
    if (idx == DIGIT_HL || idx == DIGIT_ML) seg_next = seg_next & DP_MASK;
    if (blank) seg_next = SEG_OFF;
  end

  // Registered outputs: follow idx by one cycle, exactly one digit enabled.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      seg_q <= SEG_OFF;
      dig_q <= 6'h3F;
    end else begin
      seg_q <= seg_next;
      dig_q <= dig_enable(idx);
    end
  end

  assign SEG = seg_q;
  assign DIG = dig_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Bench for clock_display_scan with SCAN_DIV=4, BLINK_FRAMES=2.
// A time-based model derives the expected SEG/DIG from the number of clock
// edges since reset release; a per-cycle compare checks it, and directed
// literal checks pin key points of the model.
module tb_clock_display_scan;

  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = SCAN_DIV * 6;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [3:0] Hh = '0, Hl = '0, Mh = '0, Ml = '0, Sh = '0, Sl = '0;
  logic       isFull = 1'b0;
  logic [7:0] SEG;
  logic [5:0] DIG;

  int vectors     = 0;
  int miscompares = 0;
  logic done = 1'b0;

  clock_display_scan #(
    .SCAN_DIV     (SCAN_DIV),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .Hh     (Hh),
    .Hl     (Hl),
    .Mh     (Mh),
    .Ml     (Ml),
    .Sh     (Sh),
    .Sl     (Sl),
    .isFull (isFull),
    .SEG    (SEG),
    .DIG    (DIG)
  );

  // Clock / reset block.
  always #5 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  int         n = 0;          // clock edges since reset release
  logic [3:0] msnap [6] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
  logic       mfull = 1'b0;
  int         run = 0;        // consecutive captured frames with isFull=1
  logic [7:0] exp_seg = 8'hFF;
  logic [5:0] exp_dig = 6'h3F;

  function automatic logic model_blank(input logic full, input int r);
`ifdef DISP_FULL_BLINK_EN
    return full && (r > 0) && ((((r - 1) / BLINK_FRAMES) % 2) == 1);
`else
    return 1'b0 & full & (r != 0);
`endif
  endfunction

  function automatic logic [7:0] model_seg(input logic [3:0] d, input int pos,
                                           input logic blank);
    logic [7:0] s;
    if (blank) return 8'hFF;
    s = (d > 4'd9) ? 8'hBF : seg_tab[d];
    if (pos == 1 || pos == 3) s[7] = 1'b0;
    return s;
  endfunction

  function automatic logic [5:0] model_dig(input int pos);
    return 6'h3F ^ (6'd1 << pos);
  endfunction

  // Output at edge n+1 shows digit (n / SCAN_DIV) % 6 of the frame captured
  // at the last frame-wrap edge.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      n       <= 0;
      exp_seg <= 8'hFF;
      exp_dig <= 6'h3F;
      for (int i = 0; i < 6; i++) msnap[i] <= 4'd0;
      mfull   <= 1'b0;
      run     <= 0;
    end else begin
      exp_dig <= model_dig((n / SCAN_DIV) % 6);
      exp_seg <= model_seg(msnap[(n / SCAN_DIV) % 6], (n / SCAN_DIV) % 6,
                           model_blank(mfull, run));
      n <= n + 1;
      if ((n % FRAME) == FRAME - 1) begin
        msnap[0] <= Hh; msnap[1] <= Hl; msnap[2] <= Mh;
        msnap[3] <= Ml; msnap[4] <= Sh; msnap[5] <= Sl;
        mfull    <= isFull;
        run      <= isFull ? run + 1 : 0;
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge CLK) begin
    if (!done) begin
      vectors++;
      if (SEG !== exp_seg || DIG !== exp_dig) begin
        miscompares++;
        $display("FAIL cycle n=%0d: SEG=%h DIG=%h, expected SEG=%h DIG=%h",
                 n, SEG, DIG, exp_seg, exp_dig);
      end
      vectors++;
      if ($countones(~DIG) > 1) begin
        miscompares++;
        $display("FAIL one_digit n=%0d: DIG=%h has more than one digit enabled", n, DIG);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk_lit(input string name, input logic [7:0] s, input logic [5:0] d);
    vectors++;
    if (SEG !== s || DIG !== d) begin
      miscompares++;
      $display("FAIL %s: SEG=%h DIG=%h, expected SEG=%h DIG=%h", name, SEG, DIG, s, d);
    end
  endtask

  task automatic goto(input int target);
    int guard;
    guard = 0;
    while (n < target && guard < 2000) begin
      @(negedge CLK);
      guard++;
    end
    vectors++;
    if (n < target) begin
      miscompares++;
      $display("FAIL goto_timeout: n=%0d, expected to reach %0d", n, target);
    end
  endtask

  task automatic set_time(input logic [3:0] a, b, c, d, e, f);
    Hh = a; Hl = b; Mh = c; Ml = d; Sh = e; Sl = f;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [7:0] blink_seg;
`ifdef DISP_FULL_BLINK_EN
    blink_seg = 8'hFF;
`else
    blink_seg = 8'hBF;
`endif

    // 1: reset, then one frame of 00.00.00.
    repeat (3) @(negedge CLK);
    chk_lit("reset_dark", 8'hFF, 6'h3F);
    #2 RST = 1'b1;
    goto(1);  chk_lit("walk_idx0", 8'hC0, 6'h3E);
    goto(5);  chk_lit("walk_idx1", 8'h40, 6'h3D);
    goto(9);  chk_lit("walk_idx2", 8'hC0, 6'h3B);
    goto(13); chk_lit("walk_idx3", 8'h40, 6'h37);
    goto(17); chk_lit("walk_idx4", 8'hC0, 6'h2F);
    goto(21); chk_lit("walk_idx5", 8'hC0, 6'h1F);

    // 2: 12.34.59 captured at the wrap.
    set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9);
    goto(25); chk_lit("t2_hh", 8'hF9, 6'h3E);
    goto(29); chk_lit("t2_hl", 8'h24, 6'h3D);
    goto(33); chk_lit("t2_mh", 8'hB0, 6'h3B);
    goto(37); chk_lit("t2_ml", 8'h19, 6'h37);
    goto(41); chk_lit("t2_sh", 8'h92, 6'h2F);
    goto(45); chk_lit("t2_sl", 8'h90, 6'h1F);

    // 3: Sl=3 for a frame, then 3->7 in mid-frame.
    Sl = 4'd3;
    goto(52); Sl = 4'd7;
    goto(69); chk_lit("t3_sl_old", 8'hB0, 6'h1F);
    goto(93); chk_lit("t3_sl_new", 8'hF8, 6'h1F);

    // 4: non-BCD hour tens shows a dash.
    Hh = 4'hC;
    goto(97);  chk_lit("t4_dash", 8'hBF, 6'h3E);
    goto(101); chk_lit("t4_hl", 8'h24, 6'h3D);

    // 5: isFull held, dropped during a dark frame.
    isFull = 1'b1;
    goto(121); chk_lit("t5_vis1", 8'hBF, 6'h3E);
    goto(145); chk_lit("t5_vis2", 8'hBF, 6'h3E);
    goto(169); chk_lit("t5_blank1", blink_seg, 6'h3E);
    goto(193); chk_lit("t5_blank2", blink_seg, 6'h3E);
    goto(200); isFull = 1'b0;
    goto(217); chk_lit("t5_drop", 8'hBF, 6'h3E);
    goto(241); chk_lit("t5_after", 8'hBF, 6'h3E);

    // 6: reset at idx=3, prescaler=2.
    goto(254);
    #2 RST = 1'b0;
    #1 chk_lit("t6_reset_now", 8'hFF, 6'h3F);
    repeat (2) @(negedge CLK);
    chk_lit("t6_reset_hold", 8'hFF, 6'h3F);
    #2 RST = 1'b1;
    goto(1);  chk_lit("t6_idx0_zero", 8'hC0, 6'h3E);
    goto(5);  chk_lit("t6_idx1_zero", 8'h40, 6'h3D);
    goto(21); chk_lit("t6_idx5_zero", 8'hC0, 6'h1F);
    goto(25); chk_lit("t6_new_frame", 8'hBF, 6'h3E);
    goto(30);

    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
